// File: rtl/ace_req_arbiter.sv
// Round-robin arbiter that shares one ACE master controller between NUM_REQ
// cache-side requesters. It latches the winner's type and address, holds one
// request line until ace_ready_i, and inserts a one-cycle gap after each
// transaction so the controller can accept a pending snoop. Issues are held
// back for a bounded number of cycles while a snoop is visible, and a watchdog
// flags transactions that never complete.
module ace_req_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 32,
    parameter int SNOOP_DEFER_MAX = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [2*NUM_REQ-1:0]        req_type_i,
    input  logic [ADDR_W*NUM_REQ-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]          req_gnt_o,
    output logic [NUM_REQ-1:0]          req_done_o,
    output logic                        read_req_o,
    output logic                        write_req_o,
    output logic                        invalid_req_o,
    output logic [ADDR_W-1:0]           ace_addr_o,
    input  logic                        ace_ready_i,
    input  logic                        ac_valid_i,
    input  logic                        err_clr_i,
    output logic                        timeout_o,
    output logic                        illegal_o,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0]       TYPE_READ    = 2'b00;
    localparam logic [1:0]       TYPE_WRITE   = 2'b01;
    localparam logic [1:0]       TYPE_UNIQUE  = 2'b10;
    localparam logic [1:0]       TYPE_ILLEGAL = 2'b11;
    localparam logic [3:0]       DEFER_MAX    = 4'(SNOOP_DEFER_MAX);
    localparam logic [WD_W-1:0]  WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [1:0]         type_q, type_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         defer_q, defer_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic               illegal_q, illegal_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] bad_type;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;

    // Per-requester classification: a valid request is eligible unless its type is illegal.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_class
            assign eligible[gi] = req_valid_i[gi] && (req_type_i[2*gi +: 2] != TYPE_ILLEGAL);
            assign bad_type[gi] = req_valid_i[gi] && (req_type_i[2*gi +: 2] == TYPE_ILLEGAL);
        end
    endgenerate

    // Round-robin search: first eligible requester after the last winner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic: arbitration and snoop deferral in IDLE, completion in ISSUE.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        type_d     = type_q;
        addr_d     = addr_q;
        defer_d    = defer_q;
        wdog_d     = wdog_q;
        req_gnt_o  = '0;
        req_done_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (!found) begin
                    defer_d = '0;
                end else if (rst_n) begin
                    if (ac_valid_i && (defer_q < DEFER_MAX)) begin
                        defer_d = defer_q + 4'd1;
                    end else begin
                        req_gnt_o[pick] = 1'b1;
                        ptr_d   = pick;
                        win_d   = pick;
                        type_d  = req_type_i[2*pick +: 2];
                        addr_d  = req_addr_i[ADDR_W*pick +: ADDR_W];
                        defer_d = '0;
                        wdog_d  = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wdog_d = (wdog_q == WD_LAST) ? wdog_q : wdog_q + 1'b1;
                if (ace_ready_i) begin
                    req_done_o[win_q] = 1'b1;
                    wdog_d  = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error flags: a new error in the same cycle wins over a clear.
    always_comb begin
        timeout_d = timeout_q;
        illegal_d = illegal_q;
        if (err_clr_i) begin
            timeout_d = 1'b0;
            illegal_d = 1'b0;
        end
        if ((state_q == ST_ISSUE) && (wdog_q == WD_LAST)) begin
            timeout_d = 1'b1;
        end
        if (|bad_type) begin
            illegal_d = 1'b1;
        end
    end

    // State and datapath registers; reset drops any in-flight request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            win_q     <= '0;
            type_q    <= TYPE_READ;
            addr_q    <= '0;
            defer_q   <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            defer_q   <= defer_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy_o        = (state_q == ST_ISSUE);
    assign read_req_o    = busy_o && (type_q == TYPE_READ);
    assign write_req_o   = busy_o && (type_q == TYPE_WRITE);
    assign invalid_req_o = busy_o && (type_q == TYPE_UNIQUE);
    assign ace_addr_o    = addr_q;
    assign timeout_o     = timeout_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_ace_req_arbiter.sv
// Self-checking bench for ace_req_arbiter: a transaction-level model predicts
// every output each cycle, and directed scenarios pin timing with literal values.
module tb_ace_req_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DMAX = 4;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [2*N-1:0]  req_type_i = '0;
    logic [AW*N-1:0] req_addr_i = '0;
    logic [N-1:0]    req_gnt_o;
    logic [N-1:0]    req_done_o;
    logic            read_req_o, write_req_o, invalid_req_o;
    logic [AW-1:0]   ace_addr_o;
    logic            ace_ready_i = 1'b0;
    logic            ac_valid_i = 1'b0;
    logic            err_clr_i = 1'b0;
    logic            timeout_o, illegal_o, busy_o;

    ace_req_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .SNOOP_DEFER_MAX(DMAX), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_type_i(req_type_i), .req_addr_i(req_addr_i),
        .req_gnt_o(req_gnt_o), .req_done_o(req_done_o),
        .read_req_o(read_req_o), .write_req_o(write_req_o), .invalid_req_o(invalid_req_o),
        .ace_addr_o(ace_addr_o), .ace_ready_i(ace_ready_i), .ac_valid_i(ac_valid_i),
        .err_clr_i(err_clr_i), .timeout_o(timeout_o), .illegal_o(illegal_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = waiting for work, 1 = transaction outstanding, 2 = mandatory idle slot
    int          m_phase = 0, m_last = N - 1, m_win = 0, m_kind = 0, m_defer = 0, m_wait = 0;
    logic [31:0] m_addr = '0;
    bit          m_to = 0, m_ill = 0;
    int          n_phase = 0, n_last = N - 1, n_win = 0, n_kind = 0, n_defer = 0, n_wait = 0;
    logic [31:0] n_addr = '0;
    bit          n_to = 0, n_ill = 0;

    function automatic bit elig(input int j);
        return req_valid_i[j] && (req_type_i[2*j +: 2] != 2'b11);
    endfunction

    function automatic bit any_bad();
        bit b = 0;
        for (int j = 0; j < N; j++)
            if (req_valid_i[j] && req_type_i[2*j +: 2] == 2'b11) b = 1;
        return b;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] e_gnt, e_done;
        logic [2:0]   e_req;
        int           w;
        if (!rst_n) begin
            m_phase = 0; m_last = N - 1; m_win = 0; m_kind = 0; m_defer = 0; m_wait = 0;
            m_addr = '0; m_to = 0; m_ill = 0;
            n_phase = 0; n_last = N - 1; n_win = 0; n_kind = 0; n_defer = 0; n_wait = 0;
            n_addr = '0; n_to = 0; n_ill = 0;
            chk("model_reset_outputs",
                {req_gnt_o, req_done_o, read_req_o, write_req_o, invalid_req_o,
                 busy_o, timeout_o, illegal_o, ace_addr_o}, 64'd0);
        end else begin
            e_gnt = '0; e_done = '0; e_req = '0; w = -1;
            n_phase = m_phase; n_last = m_last; n_win = m_win; n_kind = m_kind;
            n_defer = m_defer; n_wait = m_wait; n_addr = m_addr;
            n_ill = any_bad() ? 1'b1 : (err_clr_i ? 1'b0 : m_ill);
            n_to  = err_clr_i ? 1'b0 : m_to;
            if (m_phase == 0) begin
                for (int k = 1; k <= N; k++)
                    if (w < 0 && elig((m_last + k) % N)) w = (m_last + k) % N;
                if (w < 0) begin
                    n_defer = 0;
                end else if (ac_valid_i && m_defer < DMAX) begin
                    n_defer = m_defer + 1;
                end else begin
                    e_gnt[w] = 1'b1;
                    n_phase = 1; n_last = w; n_win = w; n_defer = 0; n_wait = 0;
                    n_kind  = int'(req_type_i[2*w +: 2]);
                    n_addr  = req_addr_i[AW*w +: AW];
                end
            end else if (m_phase == 1) begin
                e_req  = (m_kind == 0) ? 3'b100 : ((m_kind == 1) ? 3'b010 : 3'b001);
                n_wait = m_wait + 1;
                if (m_wait + 1 >= TO) n_to = 1'b1;
                if (ace_ready_i) begin
                    e_done[m_win] = 1'b1;
                    n_phase = 2;
                    n_wait  = 0;
                    $display("txn: requester %0d kind %0d addr %08h done at cycle %0d",
                             m_win, m_kind, m_addr, cyc);
                end
            end else begin
                n_phase = 0;
            end
            chk("model_gnt", req_gnt_o, e_gnt);
            chk("model_done", req_done_o, e_done);
            chk("model_req", {read_req_o, write_req_o, invalid_req_o}, e_req);
            chk("model_addr", ace_addr_o, m_addr);
            chk("model_busy", busy_o, m_phase == 1);
            chk("model_flags", {timeout_o, illegal_o}, {m_to, m_ill});
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_phase <= n_phase; m_last <= n_last; m_win <= n_win; m_kind <= n_kind;
            m_defer <= n_defer; m_wait <= n_wait; m_addr <= n_addr;
            m_to <= n_to; m_ill <= n_ill;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a grant; returns in the cycle after the grant.
    task automatic wait_gnt(output int who, output int at);
        who = -1;
        at  = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req_gnt_o != '0) begin
                who = (req_gnt_o == 2'b10) ? 1 : 0;
                at  = cyc;
            end
            next_cyc();
            if (who >= 0) break;
        end
        if (who < 0) begin
            checks++;
            errors++;
            $display("FAIL gnt_wait: no grant within 30 cycles (cycle %0d)", cyc);
        end
    endtask

    int who, gc, t0, prev_done;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_addr", ace_addr_o, 32'h0);
        chk("reset_flags", {timeout_o, illegal_o}, 2'b00);
        next_cyc();

        // Single read from requester 0, ready 5 cycles after grant.
        req_valid_i = 2'b01; req_type_i = 4'b0000; req_addr_i = {32'h0, 32'h0000_1000};
        t0 = cyc;
        wait_gnt(who, gc);
        chk("rd_who", who, 0);
        chk("rd_gnt_latency", gc - t0, 0);
        req_valid_i = 2'b00;
        @(negedge clk);
        chk("rd_req", {read_req_o, write_req_o, invalid_req_o}, 3'b100);
        chk("rd_addr", ace_addr_o, 32'h0000_1000);
        repeat (4) next_cyc();
        ace_ready_i = 1'b1;
        @(negedge clk);
        chk("rd_done", req_done_o, 2'b01);
        chk("rd_req_at_done", read_req_o, 1'b1);
        next_cyc();
        ace_ready_i = 1'b0;
        @(negedge clk);
        chk("rd_req_dropped", read_req_o, 1'b0);
        chk("rd_gap_busy", busy_o, 1'b0);
        next_cyc();

        // ace_ready outside ISSUE must be ignored.
        ace_ready_i = 1'b1;
        @(negedge clk);
        chk("stray_ready_done", req_done_o, 2'b00);
        next_cyc();
        ace_ready_i = 1'b0;

        // Round robin between write (req 0) and make-unique (req 1).
        do_reset();
        req_valid_i = 2'b11; req_type_i = 4'b1001; req_addr_i = {32'h0000_B000, 32'h0000_A000};
        prev_done = 0;
        for (int t = 0; t < 4; t++) begin
            wait_gnt(who, gc);
            chk("rr_who", who, t % 2);
            if (t > 0) chk("rr_spacing", gc - prev_done, 2);
            @(negedge clk);
            chk("rr_req", {read_req_o, write_req_o, invalid_req_o}, (who == 0) ? 3'b010 : 3'b001);
            chk("rr_addr", ace_addr_o, (who == 0) ? 32'h0000_A000 : 32'h0000_B000);
            next_cyc();
            ace_ready_i = 1'b1;
            @(negedge clk);
            chk("rr_done", req_done_o, (who == 0) ? 2'b01 : 2'b10);
            prev_done = cyc;
            next_cyc();
            ace_ready_i = 1'b0;
            if (t == 3) req_valid_i = 2'b00;
        end
        next_cyc();

        // Snoop deferral: held snoop, then snoop dropping after 2 cycles.
        do_reset();
        ac_valid_i = 1'b1; req_valid_i = 2'b10; req_type_i = 4'b0000;
        req_addr_i = {32'h0000_C000, 32'h0};
        t0 = cyc;
        wait_gnt(who, gc);
        chk("snp_who", who, 1);
        chk("snp_held_delay", gc - t0, 4);
        req_valid_i = 2'b00; ac_valid_i = 1'b0;
        next_cyc();
        ace_ready_i = 1'b1;
        next_cyc();
        ace_ready_i = 1'b0;
        next_cyc();
        req_valid_i = 2'b10; ac_valid_i = 1'b1;
        t0 = cyc;
        next_cyc();
        next_cyc();
        ac_valid_i = 1'b0;
        wait_gnt(who, gc);
        chk("snp_drop_delay", gc - t0, 2);
        req_valid_i = 2'b00;
        next_cyc();
        ace_ready_i = 1'b1;
        next_cyc();
        ace_ready_i = 1'b0;
        next_cyc();

        // Illegal type on req 0 while req 1 reads.
        do_reset();
        req_valid_i = 2'b11; req_type_i = 4'b0011; req_addr_i = {32'h0000_D000, 32'h0000_E000};
        wait_gnt(who, gc);
        chk("ill_who", who, 1);
        req_valid_i = 2'b00;
        @(negedge clk);
        chk("ill_set", illegal_o, 1'b1);
        chk("ill_addr", ace_addr_o, 32'h0000_D000);
        next_cyc();
        ace_ready_i = 1'b1;
        next_cyc();
        ace_ready_i = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("ill_sticky", illegal_o, 1'b1);
        next_cyc();
        err_clr_i = 1'b1;
        next_cyc();
        err_clr_i = 1'b0;
        @(negedge clk);
        chk("ill_cleared", illegal_o, 1'b0);
        next_cyc();

        // Watchdog: ready withheld past TIMEOUT_CYCLES.
        do_reset();
        req_valid_i = 2'b01; req_type_i = 4'b0000; req_addr_i = {32'h0, 32'h0000_F000};
        wait_gnt(who, gc);
        req_valid_i = 2'b00;
        repeat (7) next_cyc();
        @(negedge clk);
        chk("wd_before", timeout_o, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("wd_set", timeout_o, 1'b1);
        chk("wd_req_held", read_req_o, 1'b1);
        next_cyc();
        ace_ready_i = 1'b1;
        @(negedge clk);
        chk("wd_late_done", req_done_o, 2'b01);
        next_cyc();
        ace_ready_i = 1'b0;
        err_clr_i = 1'b1;
        @(negedge clk);
        chk("wd_gap", {busy_o, read_req_o}, 2'b00);
        next_cyc();
        err_clr_i = 1'b0;
        @(negedge clk);
        chk("wd_cleared", timeout_o, 1'b0);
        next_cyc();

        // Asynchronous reset in the middle of a transaction.
        do_reset();
        req_valid_i = 2'b10; req_type_i = 4'b0000; req_addr_i = {32'h0000_1234, 32'h0000_5678};
        wait_gnt(who, gc);
        chk("rst_pre_who", who, 1);
        #2;
        chk("rst_pre_busy", busy_o, 1'b1);
        ace_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_req_drop", {read_req_o, write_req_o, invalid_req_o}, 3'b000);
        chk("rst_no_done", req_done_o, 2'b00);
        next_cyc();
        ace_ready_i = 1'b0;
        rst_n = 1'b1;
        req_valid_i = 2'b11;
        wait_gnt(who, gc);
        chk("rst_first_winner", who, 0);
        req_valid_i = 2'b00;
        next_cyc();
        ace_ready_i = 1'b1;
        next_cyc();
        ace_ready_i = 1'b0;
        repeat (2) next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ace_req_arbiter.md
Name: ace_req_arbiter

Overview:
- Shares the single ACE master controller between NUM_REQ cache-side requesters (e.g. miss handler, writeback buffer, upgrade unit).
- Grants requesters round-robin and latches the winner's type and address.
- Holds exactly one of read_req/write_req/invalid_req to the ACE controller until its ace_ready completion pulse.
- Defers new issues while a snoop is pending so snoops get an IDLE slot, with a bounded starvation limit and a transaction watchdog.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 32, request address width.
- SNOOP_DEFER_MAX, 4, maximum consecutive cycles an issue is deferred for ac_valid_i; legal range 1..15.
- TIMEOUT_CYCLES, 1024, ISSUE cycles without ace_ready before timeout_o sets; must be ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester request valid (level)
- req_type_i  in  2*NUM_REQ  per-requester type, slice [2i+1:2i]: 00 read-shared, 01 write-clean, 10 make-unique, 11 illegal
- req_addr_i  in  ADDR_W*NUM_REQ  per-requester address
- req_gnt_o  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted and latched
- req_done_o  out  NUM_REQ  one-hot, 1-cycle pulse: transaction completed
- read_req_o  out  1  to ACE controller read_req
- write_req_o  out  1  to ACE controller write_req
- invalid_req_o  out  1  to ACE controller invalid_req
- ace_addr_o  out  ADDR_W  latched address of the active transaction
- ace_ready_i  in  1  completion pulse from ACE controller
- ac_valid_i  in  1  snoop address valid (AC_VALID observed)
- err_clr_i  in  1  clears sticky error flags
- timeout_o  out  1  sticky watchdog flag
- illegal_o  out  1  sticky: type 11 seen on a valid request
- busy_o  out  1  high in ISSUE

Behaviour:
- Reset values:
  - All outputs 0; ace_addr_o 0.
  - State IDLE; RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Defer counter 0; watchdog counter 0.
- States: IDLE, ISSUE, GAP.
- Eligibility: req_valid_i[i]=1 and type≠11. A valid request with type 11 is never granted and sets illegal_o in that cycle's next edge.
- IDLE:
  - Arbitrates only when some requester is eligible.
  - Round-robin search starts at pointer+1 mod NUM_REQ.
  - If ac_valid_i=1 and the defer counter < SNOOP_DEFER_MAX: no grant, the defer counter increments, stay IDLE.
  - Otherwise: pulse req_gnt_o[w], latch type/address of w, pointer←w, defer counter←0, go to ISSUE next cycle.
  - With no eligible request, the defer counter clears.
- ISSUE:
  - Exactly one of read_req_o/write_req_o/invalid_req_o is held high per the latched type (00/01/10).
  - ace_addr_o is stable throughout.
  - The watchdog counter increments each cycle and saturates.
  - On ace_ready_i=1: pulse req_done_o[w] in the same cycle (combinational), drop the request the next cycle, clear the watchdog, go to GAP.
- GAP:
  - Exactly 1 cycle with no request asserted, so the ACE controller sits in IDLE and can accept a pending snoop.
  - Then go to IDLE; no grant is issued in GAP.
- Grant-to-request latency: gnt in cycle N, req_*_o high from cycle N+1.
- Back-to-back minimum spacing: done at cycle M, next gnt at M+2 at earliest (GAP at M+1, IDLE arbitration at M+2).
- ace_ready_i outside ISSUE is ignored (no done pulse, no state change).
- Requester deasserting req_valid_i after grant has no effect on the issued transaction.
- Watchdog:
  - When the counter reaches TIMEOUT_CYCLES-1 in ISSUE, timeout_o sets next edge.
  - The request stays asserted; there is no abort.
- err_clr_i clears timeout_o and illegal_o; setting has priority over clearing in the same cycle.
- Asynchronous reset mid-ISSUE: request outputs drop immediately, with no done pulse. Requesters must reissue.
- busy_o = (state==ISSUE).

Test Plan:
- Single read: req_valid_i=01, type 00, addr 0x1000; ace_ready_i 5 cycles after grant → gnt[0] at T, read_req_o=1 and ace_addr_o=0x1000 from T+1, done[0] in the ace_ready cycle, read_req_o=0 next cycle.
- Round-robin: both requesters valid continuously (write, make-unique) → grants alternate 0,1,0,1; write_req_o/invalid_req_o match; each gnt ≥2 cycles after the previous done.
- Snoop defer: req 1 valid with ac_valid_i held high, SNOOP_DEFER_MAX=4 → no grant for 4 cycles, grant on 5th; with ac_valid_i dropping after 2 cycles → grant on 3rd.
- Illegal type: req 0 type 11 plus req 1 type 00 → only req 1 granted, illegal_o=1 sticky; err_clr_i pulse → illegal_o=0.
- Watchdog: TIMEOUT_CYCLES=8, ace_ready_i withheld → timeout_o=1 after 8 ISSUE cycles; a later ace_ready_i still produces done and GAP.
- Reset in ISSUE: assert rst_n=0 mid-transaction → all req outputs 0 immediately, no done pulse; after release requester 0 wins first arbitration.
